mod6_down_counter: RTL and testbench
====================================

MOD6_DOWN_COUNTER -- requirements
Module: mod6_down_counter

Interface
REQ-001 The block SHALL have parameter MODULUS, default 6, meaning the count sequence length, legal range 2..2**WIDTH.
REQ-002 The block SHALL have parameter WIDTH, default 3, meaning the count register width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the falling edge of clk.
REQ-004 The block SHALL have port clr, input, 1, synchronous active-high reset, sampled on the falling edge of clk.
REQ-005 The block SHALL have port en, input, 1, count enable; decrement by one per enabled edge.
REQ-006 The block SHALL have port load, input, 1, synchronous parallel-load strobe.
REQ-007 The block SHALL have port d, input, WIDTH, parallel-load value.
REQ-008 The block SHALL have port q, output, WIDTH, registered current count.
REQ-009 The block SHALL have port tc, output, 1, combinational terminal count, high when q == 0.
REQ-010 The block SHALL have port borrow, output, 1, combinational cascade borrow = tc & en & ~load & ~clr.
REQ-011 The block SHALL have port dec, output, MODULUS, combinational one-hot decode of q (dec[q] = 1).
REQ-012 The block SHALL have port load_err, output, 1, registered one-cycle flag for an out-of-range load.

Function
REQ-013 Priority on each falling edge SHALL be clr > load > en > hold.
REQ-014 With en = 1 and load = 0, q SHALL step MODULUS-1 -> MODULUS-2 -> ... -> 0 -> MODULUS-1 (5,4,3,2,1,0,5 for default).
REQ-015 Wrap from 0 to MODULUS-1 SHALL occur on the same edge as any other decrement, with no intermediate state visible on q.
REQ-016 With en = 0 and load = 0, q SHALL hold its value.
REQ-017 With load = 1 and d < MODULUS, q SHALL take d on that edge, regardless of en.
REQ-018 With load = 1 and d >= MODULUS, q SHALL take MODULUS-1, and load_err SHALL be 1 for exactly the following cycle.
REQ-019 load_err SHALL be 0 on every edge without an out-of-range load.
REQ-020 The count SHALL never hold a value >= MODULUS at any clock edge.
REQ-021 tc and dec SHALL depend only on q; borrow SHALL go high in the cycle where q = 0 and en = 1, so a cascaded stage decrements on the same edge at which this stage wraps.
REQ-022 Latency SHALL be one falling edge from en, load or clr to the q update.

Reset
REQ-023 When clr = 1 at a falling edge, q SHALL become MODULUS-1 (5), and load_err SHALL become 0, overriding load and en.
REQ-024 While clr = 1, borrow SHALL be 0; tc and dec SHALL follow the reset value of q (tc = 0, dec = 6'b100000).
REQ-025 clr asserted mid-sequence SHALL restart the sequence from MODULUS-1 on the first edge after clr deasserts with en = 1 (5 -> 4).
REQ-026 Before the first clr, output values SHALL be unspecified; the bench SHALL apply clr for at least one edge.

Verification
REQ-027 Reset then en = 1 for 13 edges -> q = 5,4,3,2,1,0,5,4,3,2,1,0,5,4; tc high only when q = 0; borrow high in the same cycles.
REQ-028 q = 3, en = 0 for 4 edges -> q stays 3; borrow = 0; dec = 6'b001000.
REQ-029 load = 1, d = 2, en = 1 -> q = 2 next edge; then load = 1, d = 7 -> q = 5 and load_err = 1 for one cycle, then 0.
REQ-030 q = 0, en = 1, load = 1, d = 4 -> borrow = 0, and q = 4 next edge (load wins, no wrap).
REQ-031 Mid-count q = 2, clr = 1 with load = 1 and en = 1 -> q = 5, load_err = 0; after clr deasserts with en = 1 -> q = 4.
REQ-032 Two instances cascaded with low.borrow driving high.en -> the 36-cycle pair sequence with high stage decrementing only on low wrap (q_hi:q_lo = 5:0 -> 4:5).

Source files
------------

// File: rtl/mod6_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod6_down_counter
// Description : Modulo-N down counter with parallel load, terminal count,
//               cascade borrow, one-hot decode and out-of-range load flag.
//               All state updates occur on the falling edge of clk.
// Ports       : clk      - single clock (falling-edge active)
//               clr      - synchronous active-high clear, count -> MODULUS-1
//               en       - count enable, decrement by one per enabled edge
//               load     - synchronous parallel-load strobe
//               d        - parallel-load value
//               q        - registered current count
//               tc       - terminal count, high when q == 0
//               borrow   - cascade borrow = tc & en & ~load & ~clr
//               dec      - one-hot decode of q
//               load_err - one-cycle flag after an out-of-range load
// Revision    : 1.0 - initial release
// ============================================================================
module mod6_down_counter #(
    parameter int MODULUS = 6,
    parameter int WIDTH   = 3
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic               load,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   q,
    output logic               tc,
    output logic               borrow,
    output logic [MODULUS-1:0] dec,
    output logic               load_err
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the compare.
    localparam logic [WIDTH:0]   C_MOD = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             load_err_q;
    logic             load_err_d;
    logic             w_d_oor;
    logic             w_cnt_oor;

    assign w_d_oor   = ({1'b0, d}       >= C_MOD);
    // Only reachable before the first clr; forcing a wrap keeps the count
    // from ever decrementing through an illegal value.
    assign w_cnt_oor = ({1'b0, count_q} >= C_MOD);

    // Next-state for load / enable / hold; clr is applied in the register.
    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        if (load) begin
            if (w_d_oor) begin
                count_d    = C_MAX;
                load_err_d = 1'b1;
            end else begin
                count_d    = d;
            end
        end else if (en) begin
            // Wrap happens in the same edge as an ordinary decrement.
            if ((count_q == '0) || w_cnt_oor) begin
                count_d = C_MAX;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(negedge clk) begin
        if (clr) begin
            count_q    <= C_MAX;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        dec = '0;
        for (int i = 0; i < MODULUS; i++) begin
            if (count_q == WIDTH'(i)) begin
                dec[i] = 1'b1;
            end
        end
    end

    assign q        = count_q;
    assign tc       = (count_q == '0);
    // Borrow is suppressed whenever this stage will not actually wrap.
    assign borrow   = tc & en & ~load & ~clr;
    assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mod6_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod6_down_counter
// Description : Self-checking bench for mod6_down_counter. Directed and
//               random steps are compared against an arithmetic reference
//               model; a two-stage cascade is checked as a mod-36 counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod6_down_counter;

    localparam int M = 6;
    localparam int W = 3;

    logic         clk;
    logic         clr;
    logic         en;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         tc;
    logic         borrow;
    logic [M-1:0] dec;
    logic         load_err;

    // cascade pair
    logic         c_clr;
    logic         c_en;
    logic [W-1:0] lo_q;
    logic [W-1:0] hi_q;
    logic         lo_tc;
    logic         hi_tc;
    logic         lo_borrow;
    logic         hi_borrow;
    logic [M-1:0] lo_dec;
    logic [M-1:0] hi_dec;
    logic         lo_err;
    logic         hi_err;
    logic [W-1:0] zero_d;

    int total = 0;
    int bad   = 0;

    // reference model state
    int mq    = 0;
    int mle   = 0;
    bit valid = 0;

    mod6_down_counter #(.MODULUS(M), .WIDTH(W)) dut (
        .clk(clk), .clr(clr), .en(en), .load(load), .d(d),
        .q(q), .tc(tc), .borrow(borrow), .dec(dec), .load_err(load_err)
    );

    mod6_down_counter #(.MODULUS(M), .WIDTH(W)) u_lo (
        .clk(clk), .clr(c_clr), .en(c_en), .load(1'b0), .d(zero_d),
        .q(lo_q), .tc(lo_tc), .borrow(lo_borrow), .dec(lo_dec), .load_err(lo_err)
    );

    mod6_down_counter #(.MODULUS(M), .WIDTH(W)) u_hi (
        .clk(clk), .clr(c_clr), .en(lo_borrow), .load(1'b0), .d(zero_d),
        .q(hi_q), .tc(hi_tc), .borrow(hi_borrow), .dec(hi_dec), .load_err(hi_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One falling edge: drive after the rising edge, check combinational
    // outputs before the falling edge, then check registered results after.
    task automatic step(input logic c, input logic l, input logic e, input logic [W-1:0] dv);
        int nq;
        int nle;
        @(posedge clk);
        clr  = c;
        load = l;
        en   = e;
        d    = dv;
        #1;
        if (valid) begin
            chk("borrow", {31'b0, borrow}, ((mq == 0) && e && !l && !c) ? 1 : 0);
            chk("tc_pre", {31'b0, tc}, (mq == 0) ? 1 : 0);
            chk("dec_pre", {26'b0, dec}, 32'(1) << mq);
        end
        if (c) begin
            nq  = M - 1;
            nle = 0;
        end else if (l) begin
            if (int'(dv) < M) begin
                nq  = int'(dv);
                nle = 0;
            end else begin
                nq  = M - 1;
                nle = 1;
            end
        end else begin
            nq  = e ? (mq + M - 1) % M : mq;
            nle = 0;
        end
        @(negedge clk);
        #1;
        mq    = nq;
        mle   = nle;
        valid = 1;
        chk("q", {29'b0, q}, mq);
        chk("load_err", {31'b0, load_err}, mle);
        chk("tc", {31'b0, tc}, (mq == 0) ? 1 : 0);
        chk("dec", {26'b0, dec}, 32'(1) << mq);
    endtask

    initial begin
        int pair;
        clr    = 1'b1;
        load   = 1'b0;
        en     = 1'b0;
        d      = '0;
        c_clr  = 1'b1;
        c_en   = 1'b0;
        zero_d = '0;

        // reset, including clr held together with load and en
        step(1, 0, 0, 0);
        chk("reset_q", {29'b0, q}, 5);
        chk("reset_dec", {26'b0, dec}, 32'b100000);
        step(1, 1, 1, 3);

        // 13 enabled edges through two wraps
        for (int i = 0; i < 13; i++) step(0, 0, 1, 0);
        chk("seq_end_q", {29'b0, q}, 4);

        // hold at 3
        step(0, 1, 0, 3);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("hold_dec", {26'b0, dec}, 32'b001000);

        // in-range load, then out-of-range load and flag clearing
        step(0, 1, 1, 2);
        step(0, 1, 0, 7);
        chk("oor_err", {31'b0, load_err}, 1);
        step(0, 0, 0, 0);
        chk("oor_err_clear", {31'b0, load_err}, 0);
        step(0, 1, 0, 6);
        step(0, 0, 1, 0);

        // load beats decrement at q == 0
        step(0, 1, 0, 0);
        step(0, 1, 1, 4);
        chk("load_wins_q", {29'b0, q}, 4);

        // clear mid-count, then restart
        step(0, 1, 0, 2);
        step(1, 1, 1, 7);
        chk("clr_err", {31'b0, load_err}, 0);
        step(0, 0, 1, 0);
        chk("restart_q", {29'b0, q}, 4);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 W'($urandom_range(0, 7)));
        end

        // cascade: hi:lo behaves as a mod-36 down counter
        @(posedge clk);
        c_clr = 1'b1;
        c_en  = 1'b0;
        @(negedge clk);
        #1;
        chk("casc_reset", {26'b0, hi_q, lo_q}, {26'b0, 3'd5, 3'd5});
        @(posedge clk);
        c_clr = 1'b0;
        c_en  = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            #1;
            pair = (35 - k + 36) % 36;
            chk("casc_pair", {26'b0, hi_q, lo_q}, {26'b0, 3'(pair / 6), 3'(pair % 6)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
